// File: rtl/fifo_sync_param.sv
// ----------------------------------------------------------------------------
// fifo_sync_param
// Parameterised single-clock FIFO with occupancy count, synchronous flush,
// programmable threshold flag and sticky over_flow/underflow error flags.
//
// Ports
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   wr_enb, datain     write request and write data
//   rd_enb             read request
//   dataout, rd_valid  registered read data; rd_valid pulses for one cycle
//                      after each accepted read
//   flush              discards all contents at the next edge
//   thresh_level       occupancy level compared against count
//   err_clear          clears the sticky error flags (a same-cycle set wins)
//   count              occupancy 0..DEPTH
//   full, empty        decoded from count
//   threshold          count >= thresh_level
//   over_flow          sticky, a write was rejected
//   underflow          sticky, a read was rejected
// ----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_enb,
    input  logic [WIDTH-1:0] datain,
    input  logic             rd_enb,
    output logic [WIDTH-1:0] dataout,
    output logic             rd_valid,
    input  logic             flush,
    input  logic [AW:0]      thresh_level,
    input  logic             err_clear,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             threshold,
    output logic             over_flow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_dataout;
    logic             r_rd_valid;
    logic             r_over_flow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_ovf_set;
    logic             w_udf_set;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // A write into a full FIFO is only taken when a read frees a slot in the
    // same cycle. A read on an empty FIFO is never taken, so there is no
    // write-to-read bypass.
    assign w_rd_acc  = ~flush & rd_enb & ~w_empty;
    assign w_wr_acc  = ~flush & wr_enb & (~w_full | rd_enb);
    assign w_ovf_set = ~flush & wr_enb & ~w_wr_acc;
    assign w_udf_set = ~flush & rd_enb & ~w_rd_acc;

    // Storage carries no reset; reset and flush discard contents by clearing
    // the pointers and count.
    always_ff @(posedge clock) begin
        if (w_wr_acc && !reset)
            r_mem[r_wp] <= datain;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_dataout   <= '0;
            r_rd_valid  <= 1'b0;
            r_over_flow <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (flush) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_count <= '0;
            end else begin
                if (w_wr_acc)
                    r_wp <= r_wp + 1'b1;
                if (w_rd_acc) begin
                    r_rp      <= r_rp + 1'b1;
                    r_dataout <= r_mem[r_rp];
                end
                if (w_wr_acc && !w_rd_acc)
                    r_count <= r_count + 1'b1;
                else if (w_rd_acc && !w_wr_acc)
                    r_count <= r_count - 1'b1;
            end
            // Set has priority over clear.
            r_over_flow <= w_ovf_set | (r_over_flow & ~err_clear);
            r_underflow <= w_udf_set | (r_underflow & ~err_clear);
        end
    end

    assign dataout   = r_dataout;
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    // count never exceeds DEPTH, so levels above DEPTH never trip and level 0
    // always trips without special casing.
    assign threshold = (r_count >= thresh_level);
    assign over_flow = r_over_flow;
    assign underflow = r_underflow;

endmodule
